demux_1to2_buf: RTL and testbench
=================================

Name: demux_1to2_buf

Overview:
- Buffered 1:2 demultiplexer: the receive-side counterpart of the 2:1 mux.
- Routes a single valid/ready input stream to one of two output lanes.
- The lane is chosen by an explicit select (S0) or by automatic round-robin deinterleaving, which undoes a time-multiplexed mux stream.
- Each lane has its own small FIFO so a stalled lane does not corrupt data; sits between a shared bus and two independent consumers.

Parameters:
- WIDTH, 8, data width of A, Z0, Z1.
- DEPTH, 2, entries per lane FIFO (power of two, >=2).
- CNT_W, 8, width of per-lane accepted-word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- A  input  WIDTH  input data word.
- S0  input  1  lane select in direct mode: 0 -> lane 0, 1 -> lane 1.
- ALT  input  1  1 = round-robin mode (S0 ignored), 0 = direct mode.
- in_valid  input  1  A/S0 valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- Z0  output  WIDTH  lane 0 head data.
- z0_valid  output  1  lane 0 FIFO non-empty.
- z0_ready  input  1  lane 0 consumer takes head.
- Z1  output  WIDTH  lane 1 head data.
- z1_valid  output  1  lane 1 FIFO non-empty.
- z1_ready  input  1  lane 1 consumer takes head.
- cnt0  output  CNT_W  words accepted into lane 0.
- cnt1  output  CNT_W  words accepted into lane 1.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Both FIFOs emptied; rr pointer=0; cnt0=cnt1=0.
  - Z0=Z1=0, z0_valid=z1_valid=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-stream discards all buffered words with no output.
- Lane select: sel = ALT ? rr : S0.
- in_ready = rst_n && !full[sel]:
  - Combinational from ALT, S0, rr and FIFO state only.
  - Never depends on in_valid or the z*_ready inputs.
- Push:
  - Occurs when in_valid && in_ready; A is written to FIFO[sel] at that edge; cnt[sel] increments.
  - Counters wrap modulo 2^CNT_W with no saturation.
- Latency: a word pushed into an empty lane appears on Zn with zn_valid=1 the cycle after acceptance. There is no same-cycle bypass.
- Pop:
  - Occurs when zn_valid && zn_ready at the edge; the head advances.
  - zn_ready while zn_valid=0 is ignored.
- Zn data:
  - Zn = FIFO head while zn_valid=1; Zn=0 while empty.
  - Zn is stable while zn_valid=1 and zn_ready=0.
- Full lane:
  - in_ready=0 when the selected lane is full, even if that lane pops in the same cycle (no push-through on full).
  - A full non-selected lane does not block traffic to the other lane.
- Empty lane with simultaneous push and pop: impossible, because zn_valid=0 means no pop occurs. Push proceeds normally.
- Non-empty, non-full lane with simultaneous push and pop: both happen; occupancy is unchanged and order is preserved.
- Round-robin pointer:
  - rr toggles only on an accepted push while ALT=1.
  - rr holds on stalls and in direct mode.
  - Switching ALT mid-stream keeps the current rr value; the first ALT word goes to lane rr.
- Order: strict FIFO per lane. No ordering is defined between lanes.
- in_valid with in_ready=0: the word is not taken. The producer holds it; the block stores nothing.

Test Plan:
- Reset then direct mode: A=8'hA5,S0=0,in_valid=1 for 1 cycle -> next cycle z0_valid=1,Z0=8'hA5,z1_valid=0,cnt0=1; pulse z0_ready -> z0_valid=0,Z0=0.
- Lane back-pressure: z0_ready=0, push 8'h01,8'h02 to lane 0 -> in_ready=0 with S0=0; with S0=1 in_ready=1, push 8'h03 -> Z1=8'h03 next cycle; release z0_ready -> Z0 shows 01 then 02.
- Round robin: ALT=1, S0=1 constant, push 10,11,12,13 with both readys=1 -> lane 0 outputs 10,12; lane 1 outputs 11,13; cnt0=cnt1=2.
- Stall holds rr: ALT=1, fill lane 0 while z0_ready=0 so rr=0 points at a full lane -> in_ready=0, rr stays 0, lane 1 receives nothing until lane 0 pops.
- Full plus pop same cycle: lane 0 full, z0_ready=1, S0=0, in_valid=1 -> in_ready=0 that cycle; the next cycle in_ready=1 and the push succeeds.
- Reset mid-operation: both lanes holding 2 words, cnt0=5; assert rst_n=0 for 1 edge -> z0_valid=z1_valid=0, Z0=Z1=0, cnt0=cnt1=0, rr=0; old data never reappears.
- Counter wrap: CNT_W=8, push 256 words to lane 1 -> cnt1 returns to 0.

Source files
------------

// File: rtl/demux_1to2_buf.sv
// Buffered 1:2 demux: one valid/ready input stream steered into two per-lane FIFOs,
// by explicit select or by round-robin deinterleave of a time-multiplexed stream.

module demux_1to2_buf_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                 occ_q, occ_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pop;

  assign valid_o = (occ_q != '0);
  assign full_o  = (occ_q == FULL_LVL);
  assign pop     = valid_o && pop_rdy_i;
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign cnt_o   = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + 1'b1;
      cnt_d       = cnt_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module demux_1to2_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic             S0,
  input  logic             ALT,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Z0,
  output logic             z0_valid,
  input  logic             z0_ready,
  output logic [WIDTH-1:0] Z1,
  output logic             z1_valid,
  input  logic             z1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int NUM_LANES = 2;

  logic                            rr_q, rr_d;
  logic                            sel, push;
  logic [NUM_LANES-1:0]            lane_push, lane_full, lane_vld, lane_rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_dout;
  logic [NUM_LANES-1:0][CNT_W-1:0] lane_cnt;

  // Ready looks only at the selected lane's fullness, never at the pop side,
  // so a full lane cannot push-through even while it drains.
  assign sel      = ALT ? rr_q : S0;
  assign in_ready = rst_n && !lane_full[sel];
  assign push     = in_valid && in_ready;
  assign lane_rdy = {z1_ready, z0_ready};

  always_comb begin
    rr_d = rr_q;
    if (push && ALT) rr_d = ~rr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_push[g] = push && (sel == 1'(g));
    demux_1to2_buf_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (lane_push[g]),
      .din_i     (A),
      .pop_rdy_i (lane_rdy[g]),
      .dout_o    (lane_dout[g]),
      .valid_o   (lane_vld[g]),
      .full_o    (lane_full[g]),
      .cnt_o     (lane_cnt[g])
    );
  end

  assign Z0       = lane_dout[0];
  assign Z1       = lane_dout[1];
  assign z0_valid = lane_vld[0];
  assign z1_valid = lane_vld[1];
  assign cnt0     = lane_cnt[0];
  assign cnt1     = lane_cnt[1];
endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed vector bench for demux_1to2_buf: each row drives inputs at negedge,
// checks the outputs seen before the next rising edge, then lets the edge happen.

module tb_demux_1to2_buf;
  logic       clk = 1'b0;
  logic       rst_n, S0, ALT, in_valid, in_ready;
  logic [7:0] A, Z0, Z1, cnt0, cnt1;
  logic       z0_valid, z0_ready, z1_valid, z1_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1to2_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .S0(S0), .ALT(ALT),
    .in_valid(in_valid), .in_ready(in_ready),
    .Z0(Z0), .z0_valid(z0_valid), .z0_ready(z0_ready),
    .Z1(Z1), .z1_valid(z1_valid), .z1_ready(z1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  typedef struct {
    logic       rst, s0, alt, iv, r0, r1;
    logic [7:0] a;
    logic       ir, v0, v1;
    logic [7:0] z0, z1, c0, c1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [7:0] a, input logic s0, alt, iv, r0, r1,
                     input logic ir, v0, input logic [7:0] z0, input logic v1,
                     input logic [7:0] z1, c0, c1);
    vec_t v;
    v.rst = rst; v.a = a; v.s0 = s0; v.alt = alt; v.iv = iv; v.r0 = r0; v.r1 = r1;
    v.ir = ir; v.v0 = v0; v.z0 = z0; v.v1 = v1; v.z1 = z1; v.c0 = c0; v.c1 = c1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; S0 = 1'b0; ALT = 1'b0; in_valid = 1'b0;
    z0_ready = 1'b0; z1_ready = 1'b0;
    repeat (2) @(posedge clk);

    //   rst a     s0 alt iv r0 r1 | ir v0 z0    v1 z1    c0    c1
    add(0, 8'h00, 0, 0, 1, 0, 0,   0, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0); // reset state
    // direct mode single word
    add(1, 8'hA5, 0, 0, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(1, 8'h00, 0, 0, 0, 1, 0,   1, 1, 8'hA5, 0, 8'h00, 8'd1, 8'd0);
    add(1, 8'h00, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd1, 8'd0);
    // lane 0 back-pressure, lane 1 still flows
    add(1, 8'h01, 0, 0, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd1, 8'd0);
    add(1, 8'h02, 0, 0, 1, 0, 0,   1, 1, 8'h01, 0, 8'h00, 8'd2, 8'd0);
    add(1, 8'h07, 0, 0, 1, 0, 0,   0, 1, 8'h01, 0, 8'h00, 8'd3, 8'd0);
    add(1, 8'h03, 1, 0, 1, 0, 0,   1, 1, 8'h01, 0, 8'h00, 8'd3, 8'd0);
    add(1, 8'h00, 1, 0, 0, 1, 0,   1, 1, 8'h01, 1, 8'h03, 8'd3, 8'd1);
    add(1, 8'h00, 1, 0, 0, 1, 0,   1, 1, 8'h02, 1, 8'h03, 8'd3, 8'd1);
    add(1, 8'h00, 1, 0, 0, 0, 1,   1, 0, 8'h00, 1, 8'h03, 8'd3, 8'd1);
    add(1, 8'h00, 1, 0, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd3, 8'd1);
    // round robin, S0 ignored
    add(1, 8'h10, 1, 1, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd3, 8'd1);
    add(1, 8'h11, 1, 1, 1, 1, 1,   1, 1, 8'h10, 0, 8'h00, 8'd4, 8'd1);
    add(1, 8'h12, 1, 1, 1, 1, 1,   1, 0, 8'h00, 1, 8'h11, 8'd4, 8'd2);
    add(1, 8'h13, 1, 1, 1, 1, 1,   1, 1, 8'h12, 0, 8'h00, 8'd5, 8'd2);
    add(1, 8'h00, 1, 1, 0, 1, 1,   1, 0, 8'h00, 1, 8'h13, 8'd5, 8'd3);
    add(1, 8'h00, 1, 1, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd5, 8'd3);
    // round robin stall: rr lands on full lane 0 and must hold
    add(1, 8'h20, 1, 1, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd5, 8'd3);
    add(1, 8'h21, 1, 1, 1, 0, 0,   1, 1, 8'h20, 0, 8'h00, 8'd6, 8'd3);
    add(1, 8'h22, 1, 1, 1, 0, 0,   1, 1, 8'h20, 1, 8'h21, 8'd6, 8'd4);
    add(1, 8'h23, 1, 1, 1, 0, 0,   1, 1, 8'h20, 1, 8'h21, 8'd7, 8'd4);
    add(1, 8'h24, 1, 1, 1, 0, 1,   0, 1, 8'h20, 1, 8'h21, 8'd7, 8'd5);
    add(1, 8'h24, 1, 1, 1, 0, 0,   0, 1, 8'h20, 1, 8'h23, 8'd7, 8'd5);
    // full lane popping in the same cycle still refuses the push
    add(1, 8'h30, 0, 0, 1, 1, 0,   0, 1, 8'h20, 1, 8'h23, 8'd7, 8'd5);
    add(1, 8'h30, 0, 0, 1, 0, 0,   1, 1, 8'h22, 1, 8'h23, 8'd7, 8'd5);
    add(1, 8'h00, 0, 0, 0, 0, 0,   0, 1, 8'h22, 1, 8'h23, 8'd8, 8'd5);
    // back to ALT: rr still 0 after direct traffic
    add(1, 8'h31, 1, 1, 1, 1, 0,   0, 1, 8'h22, 1, 8'h23, 8'd8, 8'd5);
    add(1, 8'h31, 1, 1, 1, 0, 0,   1, 1, 8'h30, 1, 8'h23, 8'd8, 8'd5);
    add(1, 8'h32, 1, 1, 1, 0, 0,   1, 1, 8'h30, 1, 8'h23, 8'd9, 8'd5);
    // reset mid-stream with both lanes full
    add(0, 8'h33, 1, 1, 1, 0, 0,   0, 1, 8'h30, 1, 8'h23, 8'd9, 8'd6);
    add(1, 8'h00, 0, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(1, 8'h00, 0, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(1, 8'h40, 1, 1, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0);
    add(1, 8'h00, 1, 1, 0, 0, 0,   1, 1, 8'h40, 0, 8'h00, 8'd1, 8'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst; A = vecs[i].a; S0 = vecs[i].s0; ALT = vecs[i].alt;
      in_valid = vecs[i].iv; z0_ready = vecs[i].r0; z1_ready = vecs[i].r1;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
      chk("z0_valid", i, 32'(z0_valid), 32'(vecs[i].v0));
      chk("Z0",       i, 32'(Z0),       32'(vecs[i].z0));
      chk("z1_valid", i, 32'(z1_valid), 32'(vecs[i].v1));
      chk("Z1",       i, 32'(Z1),       32'(vecs[i].z1));
      chk("cnt0",     i, 32'(cnt0),     32'(vecs[i].c0));
      chk("cnt1",     i, 32'(cnt1),     32'(vecs[i].c1));
    end

    // counter wrap: 256 direct pushes into lane 1, drained every cycle
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      rst_n = 1'b1; ALT = 1'b0; S0 = 1'b1; in_valid = 1'b1; A = 8'(k);
      z0_ready = 1'b0; z1_ready = 1'b1;
      #1;
      chk("wrap_in_ready", k, 32'(in_ready), 32'd1);
      if (k == 255) chk("wrap_cnt1_pre", k, 32'(cnt1), 32'd255);
    end
    @(negedge clk);
    in_valid = 1'b0; z1_ready = 1'b0;
    #1;
    chk("wrap_cnt1", 256, 32'(cnt1), 32'd0);
    chk("wrap_Z1",   256, 32'(Z1),   32'hFF);
    chk("wrap_cnt0", 256, 32'(cnt0), 32'd1);
    chk("wrap_Z0",   256, 32'(Z0),   32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
